// File: rtl/valu_seq_pkg.sv
// valu_seq shared types: lane count, sequencer states, latched command.
// Widths here are the defaults of the valu_seq parameters.
package valu_seq_pkg;

  localparam int VS_N  = 48;
  localparam int VS_AW = 16;
  localparam int VS_LW = 8;
  localparam int LANES = VS_N / 8;

  typedef enum logic [2:0] {
    IDLE,
    RDA,
    RDB,
    CAPB,
    WR,
    FIN
  } state_t;

  typedef struct packed {
    logic [4:0]       op;
    logic [VS_AW-1:0] addr_a;
    logic [VS_AW-1:0] addr_b;
    logic [VS_AW-1:0] addr_d;
    logic [VS_LW-1:0] len;
    logic [2:0]       tail;
  } cmd_t;

endpackage

// File: rtl/valu_seq_lane_mask.sv
// Tail lane count to byte-enable mask (combinational).
// Ports: i_tail valid lanes (0 or >LANES = all), o_be byte enables.
module valu_seq_lane_mask
  import valu_seq_pkg::*;
(
  input  logic [2:0]       i_tail,
  output logic [LANES-1:0] o_be
);

  always_comb begin
    o_be = '1;
    if (i_tail != 3'd0 && int'(i_tail) < LANES) begin
      for (int k = 0; k < LANES; k++) begin
        o_be[k] = (k < int'(i_tail));
      end
    end
  end

endmodule

// File: rtl/valu_seq.sv
// Vector command sequencer: D[i] = ALU(A[i], B[i]) over a word block,
// 4 cycles per word through a single-port memory and a vector ALU.
// Ports: cmd_* issue handshake, busy/done status, mem_* memory master,
// alu_ctrl/src_A/src_B/alu_result vector ALU.
// Option: VALU_SEQ_TAIL_MASK_EN masks unused lanes of the last word.
module valu_seq
  import valu_seq_pkg::*;
#(
  parameter int N  = VS_N,
  parameter int AW = VS_AW,
  parameter int LW = VS_LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [4:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr_a,
  input  logic [AW-1:0] cmd_addr_b,
  input  logic [AW-1:0] cmd_addr_d,
  input  logic [LW-1:0] cmd_len,
  input  logic [2:0]    cmd_tail,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  logic [N-1:0]  mem_rdata,
  output logic          mem_wr_en,
  output logic [N-1:0]  mem_wdata,
  output logic [N/8-1:0] mem_be,
  output logic [4:0]    alu_ctrl,
  output logic [N-1:0]  src_A,
  output logic [N-1:0]  src_B,
  input  logic [N-1:0]  alu_result
);

  state_t        r_state;
  state_t        w_next;
  cmd_t          r_cmd;
  logic [LW-1:0] r_i;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic          w_accept;
  logic          w_last;
  logic [N/8-1:0] w_be_wr;

  assign w_accept = cmd_valid && cmd_ready;
  assign w_last   = (r_i == r_cmd.len - LW'(1));

`ifdef VALU_SEQ_TAIL_MASK_EN
  logic [N/8-1:0] w_tail_be;

  valu_seq_lane_mask u_mask (
    .i_tail (r_cmd.tail),
    .o_be   (w_tail_be)
  );

  assign w_be_wr = w_last ? w_tail_be : '1;
`else
  logic w_unused_tail;

  assign w_unused_tail = ^r_cmd.tail;
  assign w_be_wr       = '1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cmd   <= '0;
      r_i     <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cmd.op     <= cmd_op;
        r_cmd.addr_a <= cmd_addr_a;
        r_cmd.addr_b <= cmd_addr_b;
        r_cmd.addr_d <= cmd_addr_d;
        r_cmd.len    <= cmd_len;
        r_cmd.tail   <= cmd_tail;
        r_i          <= '0;
      end
      if (r_state == RDB) begin
        r_a <= mem_rdata;
      end
      if (r_state == CAPB) begin
        r_b <= mem_rdata;
      end
      if (r_state == WR && !w_last) begin
        r_i <= r_i + LW'(1);
      end
    end
  end

  // Outputs are gated by rst so an abort takes effect in the
  // same cycle reset is raised, not one edge later.
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    alu_ctrl  = '0;
    src_A     = '0;
    src_B     = '0;
    if (rst) begin
      cmd_ready = 1'b1;
      w_next    = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            w_next = (cmd_len != '0) ? RDA : FIN;
          end
        end
        RDA: begin
          busy      = 1'b1;
          mem_rd_en = 1'b1;
          mem_addr  = r_cmd.addr_a + AW'(r_i);
          w_next    = RDB;
        end
        RDB: begin
          busy      = 1'b1;
          mem_rd_en = 1'b1;
          mem_addr  = r_cmd.addr_b + AW'(r_i);
          w_next    = CAPB;
        end
        CAPB: begin
          busy   = 1'b1;
          w_next = WR;
        end
        WR: begin
          busy      = 1'b1;
          mem_wr_en = 1'b1;
          mem_addr  = r_cmd.addr_d + AW'(r_i);
          mem_wdata = alu_result;
          mem_be    = w_be_wr;
          alu_ctrl  = r_cmd.op;
          src_A     = r_a;
          src_B     = r_b;
          w_next    = w_last ? FIN : RDA;
        end
        FIN: begin
          busy   = 1'b1;
          done   = 1'b1;
          w_next = IDLE;
        end
        default: begin
          w_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_valu_seq.sv
// Self-checking bench for valu_seq: memory + ALU stub, queue model
// of the expected bus stream, randomized commands.
module tb_valu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_op = '0;
  logic [15:0] cmd_addr_a = '0;
  logic [15:0] cmd_addr_b = '0;
  logic [15:0] cmd_addr_d = '0;
  logic [7:0]  cmd_len = '0;
  logic [2:0]  cmd_tail = '0;
  logic        busy;
  logic        done;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [47:0] mem_rdata = '0;
  logic        mem_wr_en;
  logic [47:0] mem_wdata;
  logic [5:0]  mem_be;
  logic [4:0]  alu_ctrl;
  logic [47:0] src_A;
  logic [47:0] src_B;
  logic [47:0] alu_result;

  int errors = 0;
  int checks = 0;

  logic [47:0] mem  [65536];
  logic [47:0] mmem [65536];
  logic [47:0] pend [logic [15:0]];

  typedef struct {
    bit          rd;
    bit          wr;
    bit          dn;
    logic [15:0] addr;
    logic [47:0] wd;
    logic [5:0]  be;
    logic [4:0]  op;
  } ev_t;

  ev_t exp_q[$];

  valu_seq dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr_a (cmd_addr_a),
    .cmd_addr_b (cmd_addr_b),
    .cmd_addr_d (cmd_addr_d),
    .cmd_len    (cmd_len),
    .cmd_tail   (cmd_tail),
    .busy       (busy),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rdata  (mem_rdata),
    .mem_wr_en  (mem_wr_en),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .alu_ctrl   (alu_ctrl),
    .src_A      (src_A),
    .src_B      (src_B),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] alu_f(logic [4:0] op,
                                        logic [47:0] a,
                                        logic [47:0] b);
    logic [47:0] r;
    r = a ^ b;
    if (op == 5'h03) begin
      for (int k = 0; k < 6; k++) r[8*k +: 8] = a[8*k +: 8] + b[8*k +: 8];
    end else if (op == 5'h01) begin
      r = a & b;
    end
    return r;
  endfunction

  function automatic logic [47:0] merge(logic [47:0] old,
                                        logic [47:0] nw,
                                        logic [5:0] be);
    logic [47:0] r;
    r = old;
    for (int k = 0; k < 6; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  function automatic logic [5:0] model_be(bit last, logic [2:0] tail);
    bit use_tail;
    int t;
    logic [5:0] m;
`ifdef VALU_SEQ_TAIL_MASK_EN
    use_tail = 1'b1;
`else
    use_tail = 1'b0;
`endif
    m = 6'b111111;
    if (use_tail && last && tail != 3'd0) begin
      t = (int'(tail) > 6) ? 6 : int'(tail);
      m = 6'((1 << t) - 1);
    end
    return m;
  endfunction

  assign alu_result = alu_f(alu_ctrl, src_A, src_B);

  // memory: one-cycle read latency, byte-enabled writes
  initial begin
    forever begin
      @(posedge clk);
      mem_rdata <= mem_rd_en ? mem[mem_addr] : 48'h0;
      if (mem_wr_en) mem[mem_addr] = merge(mem[mem_addr], mem_wdata, mem_be);
    end
  end

  task automatic check(bit ok, string nm, string act, string req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s, expected %s", nm, act, req);
    end
  endtask

  function automatic logic [47:0] rdm(logic [15:0] a);
    if (pend.exists(a)) return pend[a];
    return mmem[a];
  endfunction

  task automatic build(logic [4:0] op, logic [15:0] a, logic [15:0] b,
                       logic [15:0] d, logic [7:0] len, logic [2:0] tail);
    ev_t e;
    logic [15:0] ai, bi, di;
    logic [47:0] r;
    logic [5:0] be;
    pend.delete();
    for (int i = 0; i < int'(len); i++) begin
      ai = a + 16'(i);
      bi = b + 16'(i);
      di = d + 16'(i);
      r  = alu_f(op, rdm(ai), rdm(bi));
      be = model_be(i == int'(len) - 1, tail);
      e = '{rd: 1, wr: 0, dn: 0, addr: ai, wd: 0, be: 0, op: 0};
      exp_q.push_back(e);
      e.addr = bi;
      exp_q.push_back(e);
      e = '{rd: 0, wr: 0, dn: 0, addr: 0, wd: 0, be: 0, op: 0};
      exp_q.push_back(e);
      e = '{rd: 0, wr: 1, dn: 0, addr: di, wd: r, be: be, op: op};
      exp_q.push_back(e);
      pend[di] = merge(rdm(di), r, be);
    end
    e = '{rd: 0, wr: 0, dn: 1, addr: 0, wd: 0, be: 0, op: 0};
    exp_q.push_back(e);
  endtask

  // per-cycle compare against the expected stream
  initial begin
    ev_t e;
    bit ok;
    forever begin
      @(negedge clk);
      if (rst) begin
        ok = cmd_ready && !busy && !done && !mem_rd_en && !mem_wr_en &&
             mem_addr == 0 && mem_be == 0 && mem_wdata == 0 &&
             alu_ctrl == 0 && src_A == 0 && src_B == 0;
        check(ok, "reset_out",
          $sformatf("rdy=%0b bsy=%0b dn=%0b rd=%0b wr=%0b a=%h be=%b wd=%h op=%h",
            cmd_ready, busy, done, mem_rd_en, mem_wr_en, mem_addr,
            mem_be, mem_wdata, alu_ctrl),
          "rdy=1 and all else 0");
      end else if (exp_q.size() == 0) begin
        ok = cmd_ready && !busy && !done && !mem_rd_en && !mem_wr_en &&
             mem_be == 0;
        check(ok, "idle_out",
          $sformatf("rdy=%0b bsy=%0b dn=%0b rd=%0b wr=%0b be=%b",
            cmd_ready, busy, done, mem_rd_en, mem_wr_en, mem_be),
          "rdy=1 bsy=0 dn=0 rd=0 wr=0 be=0");
      end else begin
        e = exp_q.pop_front();
        ok = !cmd_ready && busy && done == e.dn &&
             mem_rd_en == e.rd && mem_wr_en == e.wr &&
             (!(e.rd || e.wr) || mem_addr == e.addr) &&
             (e.wr ? (mem_wdata == e.wd && mem_be == e.be &&
                      alu_ctrl == e.op) : mem_be == 0);
        check(ok, "cycle",
          $sformatf("rdy=%0b bsy=%0b dn=%0b rd=%0b wr=%0b a=%h wd=%h be=%b op=%h",
            cmd_ready, busy, done, mem_rd_en, mem_wr_en, mem_addr,
            mem_wdata, mem_be, alu_ctrl),
          $sformatf("rdy=0 bsy=1 dn=%0b rd=%0b wr=%0b a=%h wd=%h be=%b op=%h",
            e.dn, e.rd, e.wr, e.addr, e.wd, e.be, e.op));
        if (e.wr) mmem[e.addr] = merge(mmem[e.addr], e.wd, e.be);
      end
    end
  end

  task automatic poke(logic [15:0] a, logic [47:0] v);
    mem[a]  = v;
    mmem[a] = v;
  endtask

  task automatic offer(logic [4:0] op, logic [15:0] a, logic [15:0] b,
                       logic [15:0] d, logic [7:0] len, logic [2:0] tail);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_addr_a = a;
    cmd_addr_b = b;
    cmd_addr_d = d;
    cmd_len    = len;
    cmd_tail   = tail;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    build(op, a, b, d, len, tail);
  endtask

  task automatic wait_done(logic [7:0] len, bit noise, output int lat);
    lat = -1;
    for (int k = 1; k <= 4 * int'(len) + 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (noise) begin
        cmd_valid  = 1'($urandom);
        cmd_op     = 5'($urandom);
        cmd_addr_a = 16'($urandom);
        cmd_len    = 8'($urandom);
      end
    end
    cmd_valid = 1'b0;
    if (lat < 0) begin
      check(1'b0, "done_timeout", "no done", "done pulse");
      exp_q.delete();
    end
  endtask

  task automatic run(logic [4:0] op, logic [15:0] a, logic [15:0] b,
                     logic [15:0] d, logic [7:0] len, logic [2:0] tail,
                     bit noise, output int lat);
    @(posedge clk);
    #1;
    offer(op, a, b, d, len, tail);
    wait_done(len, noise, lat);
  endtask

  task automatic check_region(logic [15:0] d, logic [7:0] len);
    logic [15:0] di;
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(len); i++) begin
      di = d + 16'(i);
      check(mem[di] == mmem[di], "mem_region",
        $sformatf("mem[%h]=%h", di, mem[di]),
        $sformatf("%h", mmem[di]));
    end
  endtask

  initial begin
    logic [47:0] v;
    int lat;
    logic [4:0] op;
    logic [15:0] a, b, d;
    logic [7:0] len;
    logic [5:0] ops[4];
    ops[0] = 6'h01; ops[1] = 6'h03; ops[2] = 6'h07; ops[3] = 6'h1d;
    for (int k = 0; k < 65536; k++) begin
      v = {$urandom(), $urandom()};
      mem[k]  = v[47:0];
      mmem[k] = v[47:0];
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // single word, per-lane byte add
    poke(16'h0010, 48'h010203040506);
    poke(16'h0020, 48'h010101010101);
    run(5'h03, 16'h0010, 16'h0020, 16'h0030, 8'd1, 3'd0, 1'b0, lat);
    check(lat == 5, "t1_latency", $sformatf("%0d", lat), "5");
    check_region(16'h0030, 8'd1);
    check(mem[16'h0030] == 48'h020304050607, "t1_result",
      $sformatf("%h", mem[16'h0030]), "020304050607");

    // len 4, D overlaps B in place
    for (int i = 0; i < 4; i++) begin
      poke(16'(i), 48'(i + 1));
      poke(16'(8 + i), 48'h10);
    end
    run(5'h03, 16'h0000, 16'h0008, 16'h0008, 8'd4, 3'd0, 1'b0, lat);
    check(lat == 17, "t2_latency", $sformatf("%0d", lat), "17");
    check_region(16'h0008, 8'd4);
    for (int i = 0; i < 4; i++) begin
      check(mem[16'(8 + i)] == 48'(16'h11 + i), "t2_result",
        $sformatf("%h", mem[16'(8 + i)]), $sformatf("%h", 48'(16'h11 + i)));
    end

    // len 0
    run(5'h03, 16'h0100, 16'h0200, 16'h0300, 8'd0, 3'd0, 1'b0, lat);
    check(lat == 1, "t3_latency", $sformatf("%0d", lat), "1");
    @(negedge clk);
    check(cmd_ready == 1'b1, "t3_ready_after",
      $sformatf("%0b", cmd_ready), "1");

    // address wrap
    poke(16'hFFFF, 48'h1);
    poke(16'h0000, 48'h2);
    poke(16'h0040, 48'h0);
    poke(16'h0041, 48'h0);
    run(5'h03, 16'hFFFF, 16'h0040, 16'h0050, 8'd2, 3'd0, 1'b0, lat);
    check_region(16'h0050, 8'd2);
    check(mem[16'h0051] == 48'h2, "t4_wrap",
      $sformatf("%h", mem[16'h0051]), "000000000002");

    // reset during WR of word 1
    for (int i = 0; i < 3; i++) begin
      poke(16'(16'h90 + i), 48'h1);
      poke(16'(16'hA0 + i), 48'h1);
      poke(16'(16'hB0 + i), 48'h0);
    end
    @(posedge clk);
    #1;
    offer(5'h03, 16'h0090, 16'h00A0, 16'h00B0, 8'd3, 3'd0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check(mem[16'h00B0] == 48'h2 && mem[16'h00B1] == 48'h0 &&
          mem[16'h00B2] == 48'h0, "t5_abort",
      $sformatf("%h %h %h", mem[16'h00B0], mem[16'h00B1], mem[16'h00B2]),
      "000000000002 000000000000 000000000000");
    offer(5'h01, 16'h0090, 16'h00A0, 16'h00C0, 8'd1, 3'd0);
    wait_done(8'd1, 1'b0, lat);
    check(lat == 5, "t5_restart", $sformatf("%0d", lat), "5");
    check_region(16'h00C0, 8'd1);

    // tail mask
    for (int i = 0; i < 2; i++) begin
      poke(16'(16'h60 + i), 48'h010101010101);
      poke(16'(16'h70 + i), 48'h010101010101);
      poke(16'(16'h80 + i), 48'hAAAAAAAAAAAA);
    end
    run(5'h03, 16'h0060, 16'h0070, 16'h0080, 8'd2, 3'd3, 1'b0, lat);
    check_region(16'h0080, 8'd2);
    check(mem[16'h0080] == 48'h020202020202, "t6_word0",
      $sformatf("%h", mem[16'h0080]), "020202020202");
`ifdef VALU_SEQ_TAIL_MASK_EN
    v = 48'hAAAAAA020202;
`else
    v = 48'h020202020202;
`endif
    check(mem[16'h0081] == v, "t6_word1",
      $sformatf("%h", mem[16'h0081]), $sformatf("%h", v));

    // randomized commands, with cmd_valid noise while busy
    for (int n = 0; n < 30; n++) begin
      op = 5'(ops[$urandom_range(0, 3)]);
      if ($urandom_range(0, 1) == 0) begin
        a = 16'($urandom_range(0, 40));
        b = 16'($urandom_range(0, 40));
        d = 16'($urandom_range(0, 40));
      end else begin
        a = 16'($urandom);
        b = 16'($urandom);
        d = 16'($urandom);
      end
      len = 8'($urandom_range(0, 6));
      run(op, a, b, d, len, 3'($urandom), 1'b1, lat);
      check(lat == 4 * int'(len) + 1, "rand_latency",
        $sformatf("%0d", lat), $sformatf("%0d", 4 * int'(len) + 1));
      check_region(d, len);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/valu_seq.md
Name: valu_seq

Overview:
- Sequencer that runs one vector command over a block of 48-bit words held in a single-port data memory.
- For each word index i it reads A[i] and B[i], drives the 6-lane vector ALU (alu_ctrl/src_A/src_B), and writes alu_result to D[i].
- Sits between the command issue stage and the vector ALU plus data memory; it is the only master of both.

Parameters:
- N, 48, datapath width; must be a multiple of 8. LANES = N/8 = 6.
- AW, 16, word-address width of the data memory.
- LW, 8, width of the word-count field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  5  ALU operation, forwarded to alu_ctrl
- cmd_addr_a / cmd_addr_b / cmd_addr_d  in  AW each  base word addresses of A, B and D
- cmd_len  in  LW  number of words to process
- cmd_tail  in  3  valid lanes in the last word; 0 means all LANES
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion
- mem_addr  out  AW  memory word address
- mem_rd_en  out  1  read strobe; data is returned on mem_rdata the next cycle
- mem_rdata  in  N  read data
- mem_wr_en  out  1  write strobe
- mem_wdata  out  N  write data
- mem_be  out  N/8  byte enables; bit k covers lane k = bits [8k+7:8k]
- alu_ctrl  out  5  to the vector ALU
- src_A / src_B  out  N  to the vector ALU
- alu_result  in  N  from the vector ALU (combinational)

Behaviour:
- Reset values: state IDLE; cmd_ready=1; busy=0; done=0; mem_rd_en=0; mem_wr_en=0; mem_addr=0; mem_be=0; mem_wdata=0; alu_ctrl=0; src_A=0; src_B=0; all internal registers cleared.
- Accept: a command is accepted on a cycle where cmd_valid && cmd_ready. On accept, latch op, the three base addresses, len and tail; clear index i.
- cmd_ready is 1 only in IDLE. busy is 1 in every state except IDLE.
- States:
  - IDLE: on accept go to RDA if len != 0; if len == 0 go to FIN.
  - RDA: mem_rd_en=1, mem_addr=addr_a+i. Go to RDB.
  - RDB: mem_rd_en=1, mem_addr=addr_b+i; capture mem_rdata into reg_a. Go to CAPB.
  - CAPB: capture mem_rdata into reg_b. Go to WR.
  - WR: mem_wr_en=1, mem_addr=addr_d+i, mem_wdata=alu_result, mem_be per the optional feature. If i == len-1 go to FIN; else i++ and go to RDA.
  - FIN: done=1 for exactly this one cycle, then go to IDLE.
- ALU drive: src_A=reg_a, src_B=reg_b and alu_ctrl=latched op, held stable from CAPB+1 through WR. alu_result is sampled only in WR.
- Throughput and latency:
  - Exactly 4 cycles per word.
  - The done pulse occurs 4*len+1 cycles after the accept cycle.
  - With len=0, done is asserted the cycle after accept and no memory access is made.
- Address arithmetic is modulo 2^AW; wrap-around is silent and allowed.
- Only one memory strobe is active per cycle; mem_rd_en and mem_wr_en are never asserted together.
- Overlap: A, B and D regions may overlap. Because D[i] is written after A[i] and B[i] are read, in-place operation (D==A) is correct.
- A cmd_valid presented while busy is ignored; there is no queuing.
- Reset asserted mid-command aborts it within that cycle: no further memory strobes, no done pulse, outputs return to reset values.
- mem_be outside the WR state is 0.

Optional Feature:
- Macro: VALU_SEQ_TAIL_MASK_EN.
- Defined:
  - In WR for the last word (i == len-1) with cmd_tail != 0, mem_be bit k = (k < cmd_tail).
  - All other writes use mem_be = all ones.
  - cmd_tail values greater than LANES are treated as LANES.
- Undefined: cmd_tail is ignored and mem_be = all ones on every write. The port remains present in both builds.

Decomposition:
- Package valu_seq_pkg:
  - LANES constant.
  - State enum: IDLE, RDA, RDB, CAPB, WR, FIN.
  - Packed command struct: op, addr_a, addr_b, addr_d, len, tail.
- Sub-module valu_seq_lane_mask: combinational; tail count → N/8-bit byte enable; instantiated only under the macro.
- All other logic stays in valu_seq.

Test Plan:
- Single word, ALU stub computes a per-lane byte add. A@0x10=48'h010203040506, B@0x20=48'h010101010101, len=1, D=0x30, op=5'h03 → mem[0x30]=48'h020304050607; alu_ctrl=5'h03 during WR; done pulses at accept+5.
- len=4 from A=0x00, B=0x08, D=0x08 (D overlaps B) → four writes at 0x08..0x0B with results from the pre-write B values; exactly 16 busy cycles before FIN.
- len=0 → done the next cycle; mem_rd_en and mem_wr_en stay 0; cmd_ready returns high the cycle after done.
- Address wrap with AW=16: A=16'hFFFF, len=2 → the second read of A uses address 16'h0000.
- Reset asserted during the WR of word 1 of a len=3 command → no writes after reset, no done pulse, all outputs at reset values; a new command is accepted the cycle after reset deasserts.
- VALU_SEQ_TAIL_MASK_EN defined, len=2, tail=3 → first write mem_be=6'b111111, second write mem_be=6'b000111. With the macro undefined, both writes use 6'b111111.
